// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: ALU operation encodings used by decode and execute.
package riscv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_BLT  = 4'd12;
    localparam logic [3:0] ALU_BGE  = 4'd13;
    localparam logic [3:0] ALU_BLTU = 4'd14;
    localparam logic [3:0] ALU_BGEU = 4'd15;

endpackage

// File: rtl/riscv_alu.sv
// RV32I execute-stage ALU: arithmetic/logic/shift/compare results and branch-taken flag.
// Latency: result/zero combinational; result_q/zero_q one cycle after.
// Backpressure: none; the output registers load on every clock edge.
module riscv_alu
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_ctrl,
    output logic [31:0] result,
    output logic        zero,
    output logic [31:0] result_q,
    output logic        zero_q
);

    logic [31:0] diff;
    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;
    logic        eq;

    // One subtractor and one set of compares are shared by SUB, SLT* and every branch.
    assign diff  = a - b;
    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = (a == b);

    always_comb begin
        result = diff;
        zero   = 1'b0;
        case (alu_ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = diff;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  result = {31'b0, lt_s};
            ALU_SLTU: result = {31'b0, lt_u};
            default:  result = diff;
        endcase

        // Branch ops repurpose zero as the taken flag; everything else reports result==0.
        case (alu_ctrl)
            ALU_BEQ:  zero = eq;
            ALU_BNE:  zero = ~eq;
            ALU_BLT:  zero = lt_s;
            ALU_BGE:  zero = ~lt_s;
            ALU_BLTU: zero = lt_u;
            ALU_BGEU: zero = ~lt_u;
            default:  zero = (result == 32'd0);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 32'd0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result;
            zero_q   <= zero;
        end
    end

endmodule

// File: tb/tb_riscv_alu.sv
// Directed-vector bench for riscv_alu with a queue scoreboard and a negedge monitor.
module tb_riscv_alu;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;

    logic        vld;
    int          errors;
    int          checks;

    logic [32:0] q_comb[$];
    logic [32:0] q_reg[$];
    string       q_name[$];

    riscv_alu dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .alu_ctrl (alu_ctrl),
        .result   (result),
        .zero     (zero),
        .result_q (result_q),
        .zero_q   (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector just after a rising edge; hold it for the whole cycle.
    task automatic vec(input string nm, input logic [3:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] er, input logic ez,
                       input logic r);
        rst = r; alu_ctrl = op; a = va; b = vb; vld = 1'b1;
        q_comb.push_back({er, ez});
        q_reg.push_back(r ? 33'd0 : {er, ez});
        q_name.push_back(nm);
        @(posedge clk); #1;
    endtask

    // Drive a vector, then replace it mid-cycle; only the second one is captured.
    task automatic vec_chg(input string nm, input logic [3:0] op1, input logic [31:0] a1,
                           input logic [31:0] b1, input logic [3:0] op2,
                           input logic [31:0] a2, input logic [31:0] b2,
                           input logic [31:0] er, input logic ez);
        rst = 1'b0; alu_ctrl = op1; a = a1; b = b1; vld = 1'b1;
        #2;
        alu_ctrl = op2; a = a2; b = b2;
        q_comb.push_back({er, ez});
        q_reg.push_back({er, ez});
        q_name.push_back(nm);
        @(posedge clk); #1;
    endtask

    // Monitor: combinational check for the current vector, registered check for the previous one.
    initial begin
        logic [32:0] prev_reg;
        logic [32:0] exp_c;
        string       prev_nm;
        string       nm;
        bit          have_prev;
        have_prev = 1'b0;
        prev_reg  = '0;
        prev_nm   = "";
        forever begin
            @(negedge clk);
            if (have_prev) begin
                checks++;
                if ({result_q, zero_q} !== prev_reg) begin
                    errors++;
                    $display("FAIL reg_%s: result_q=%h zero_q=%b expected result_q=%h zero_q=%b",
                             prev_nm, result_q, zero_q, prev_reg[32:1], prev_reg[0]);
                end
                have_prev = 1'b0;
            end
            if (vld) begin
                checks++;
                if (q_comb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: got result=%h zero=%b with no expectation queued",
                             result, zero);
                end else begin
                    exp_c = q_comb.pop_front();
                    nm    = q_name.pop_front();
                    if ({result, zero} !== exp_c) begin
                        errors++;
                        $display("FAIL comb_%s: result=%h zero=%b expected result=%h zero=%b",
                                 nm, result, zero, exp_c[32:1], exp_c[0]);
                    end
                    prev_reg  = q_reg.pop_front();
                    prev_nm   = nm;
                    have_prev = 1'b1;
                end
            end
        end
    end

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; vld = 1'b0; a = '0; b = '0; alu_ctrl = ALU_ADD;
        @(posedge clk); #1;

        // Reset held for two edges with live inputs; the combinational path still works.
        vec("rst0",     ALU_ADD,  32'd2,        32'd3,        32'd5,        1'b0, 1'b1);
        vec("rst1",     ALU_ADD,  32'd2,        32'd3,        32'd5,        1'b0, 1'b1);
        vec("add_2_3",  ALU_ADD,  32'd2,        32'd3,        32'd5,        1'b0, 1'b0);
        vec_chg("hold", ALU_ADD,  32'd7,        32'd8, ALU_SUB, 32'd9, 32'd4, 32'd5, 1'b0);

        vec("add",      ALU_ADD,  32'h12345678, 32'h87654321, 32'h99999999, 1'b0, 1'b0);
        vec("add_wrap", ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
        vec("sub_bor",  ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0);
        vec("sub_eq",   ALU_SUB,  32'h0000ABCD, 32'h0000ABCD, 32'h00000000, 1'b1, 1'b0);
        vec("and",      ALU_AND,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0);
        vec("or",       ALU_OR,   32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0);
        vec("xor_eq",   ALU_XOR,  32'h5A5A5A5A, 32'h5A5A5A5A, 32'h00000000, 1'b1, 1'b0);

        vec("sll",      ALU_SLL,  32'h00000001, 32'd4,        32'h00000010, 1'b0, 1'b0);
        vec("sll_out",  ALU_SLL,  32'h80000000, 32'd1,        32'h00000000, 1'b1, 1'b0);
        vec("srl",      ALU_SRL,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0);
        vec("sra_neg",  ALU_SRA,  32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0);
        vec("sra_pos",  ALU_SRA,  32'h7FFFFFFF, 32'd4,        32'h07FFFFFF, 1'b0, 1'b0);
        vec("srl_b20",  ALU_SRL,  32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF, 1'b0, 1'b0);
        vec("sll_hi",   ALU_SLL,  32'h00000003, 32'hFFFFFFE1, 32'h00000006, 1'b0, 1'b0);

        vec("slt_t",    ALU_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        vec("slt_f",    ALU_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
        vec("sltu_f",   ALU_SLTU, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0);
        vec("sltu_t",   ALU_SLTU, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0, 1'b0);

        vec("beq_t",    ALU_BEQ,  32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0);
        vec("beq_f",    ALU_BEQ,  32'h12345678, 32'h87654321, 32'h8ACF1357, 1'b0, 1'b0);
        vec("bne_f",    ALU_BNE,  32'h00001234, 32'h00001234, 32'h00000000, 1'b0, 1'b0);
        vec("bne_t",    ALU_BNE,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b0);
        vec("blt_t",    ALU_BLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0);
        vec("blt_eq",   ALU_BLT,  32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 1'b0);
        vec("bge_t",    ALU_BGE,  32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
        vec("bge_eq",   ALU_BGE,  32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0);
        vec("bltu_t",   ALU_BLTU, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
        vec("bgeu_f",   ALU_BGEU, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        vec("bgeu_eq",  ALU_BGEU, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0);

        // Mid-stream reset, then recovery on the first edge after release.
        vec("mid_rst",  ALU_OR,   32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0, 1'b1);
        vec("post_rst", ALU_XOR,  32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0, 1'b0);

        vld = 1'b0;
        repeat (3) @(negedge clk);

        checks++;
        if (q_comb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left in scoreboard, required 0", q_comb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
